// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
// Covers the register address width, FSM state encoding and mult/div latencies.
package hazard_stall_ctrl_pkg;

  localparam int RegAddrWidth = 5;
  localparam int MUL_LAT_DEF  = 4;
  localparam int DIV_LAT_DEF  = 8;
  localparam int CNT_W_DEF    = 32;

  typedef logic [RegAddrWidth-1:0] reg_addr_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } hz_state_e;

  // Timer only needs to hold DIV_LAT-1, the longest reload value.
  function automatic int timer_width(input int div_lat);
    return (div_lat > 1) ? $clog2(div_lat) : 1;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of ID/EX hazard inputs and the pipeline control outputs of hazard_stall_ctrl.
// The slave modport is the controller's view; master is the pipeline/driver view.
interface hazard_stall_ctrl_if
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  reg_addr_t        raddr_1_ID;
  reg_addr_t        raddr_2_ID;
  logic             use_1_ID;
  logic             use_2_ID;
  logic             reads_hilo_ID;
  logic             muldiv_ID;
  logic             is_div_ID;
  logic             MemOrAlu_EX;
  logic             WriteReg_EX;
  reg_addr_t        wdest_EX;
  logic             branch_taken_ID;
  logic             WriteReg_ID;
  logic             WriteMem_ID;
  logic             MemOrAlu_ID;

  logic             hold_PC;
  logic             hold_IF_ID;
  logic             hold_ID_EX;
  logic             bubble_ID_EX;
  logic             flush_IF_ID;
  logic             muldiv_busy;
  logic [CNT_W-1:0] stall_cnt;
  logic             WriteReg_ID_EX;
  logic             WriteMem_ID_EX;
  logic             MemOrAlu_ID_EX;

  modport slave (
    input  raddr_1_ID, raddr_2_ID, use_1_ID, use_2_ID, reads_hilo_ID,
           muldiv_ID, is_div_ID, MemOrAlu_EX, WriteReg_EX, wdest_EX,
           branch_taken_ID, WriteReg_ID, WriteMem_ID, MemOrAlu_ID,
    output hold_PC, hold_IF_ID, hold_ID_EX, bubble_ID_EX, flush_IF_ID,
           muldiv_busy, stall_cnt, WriteReg_ID_EX, WriteMem_ID_EX, MemOrAlu_ID_EX
  );

  modport master (
    output raddr_1_ID, raddr_2_ID, use_1_ID, use_2_ID, reads_hilo_ID,
           muldiv_ID, is_div_ID, MemOrAlu_EX, WriteReg_EX, wdest_EX,
           branch_taken_ID, WriteReg_ID, WriteMem_ID, MemOrAlu_ID,
    input  hold_PC, hold_IF_ID, hold_ID_EX, bubble_ID_EX, flush_IF_ID,
           muldiv_busy, stall_cnt, WriteReg_ID_EX, WriteMem_ID_EX, MemOrAlu_ID_EX
  );

endinterface

// File: rtl/hazard_stall_ctrl_muldiv_timer.sv
// Loadable down-counter tracking how long HI/LO stays pending after a mult/div enters EX.
// Load wins over decrement; the count parks at zero until reloaded.
module muldiv_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use and HI/LO hazard detection producing PC/IF_ID/ID_EX hold, bubble and flush controls.
// Also gates ID-stage control bits into ID_EX and keeps a saturating stall-cycle counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_stall_ctrl_if.slave bus
);

  localparam int              TMR_W    = timer_width(DIV_LAT);
  localparam logic [TMR_W-1:0] MUL_LOAD = TMR_W'(MUL_LAT - 1);
  localparam logic [TMR_W-1:0] DIV_LOAD = TMR_W'(DIV_LAT - 1);

  hz_state_e        r_state;
  logic             r_busy;
  logic [CNT_W-1:0] r_stall_cnt;

  reg_addr_t        w_src_addr [2];
  logic [1:0]       w_src_use;
  logic [1:0]       w_src_hit;
  logic             w_ld_use;
  logic             w_hilo_haz;
  logic             w_stall;
  logic             w_start;
  logic [TMR_W-1:0] w_load_val;
  logic             w_timer_zero;

  assign w_src_addr[0] = bus.raddr_1_ID;
  assign w_src_addr[1] = bus.raddr_2_ID;
  assign w_src_use[0]  = bus.use_1_ID;
  assign w_src_use[1]  = bus.use_2_ID;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign w_src_hit[gi] = w_src_use[gi] & (w_src_addr[gi] == bus.wdest_EX);
    end
  endgenerate

  // $zero is never really written, so a load targeting it cannot create a dependency.
  assign w_ld_use   = bus.MemOrAlu_EX & bus.WriteReg_EX & (bus.wdest_EX != '0) & (|w_src_hit);
  assign w_hilo_haz = r_busy & (bus.reads_hilo_ID | bus.muldiv_ID);
  assign w_stall    = w_ld_use | w_hilo_haz;

  // A stalled mult/div is not in EX yet, so it must not start the timer.
  assign w_start    = (r_state == ST_IDLE) & bus.muldiv_ID & ~w_stall;
  assign w_load_val = bus.is_div_ID ? DIV_LOAD : MUL_LOAD;

  muldiv_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_start),
    .i_load_val (w_load_val),
    .i_dec      (r_state == ST_BUSY),
    .o_zero     (w_timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_BUSY;
            r_busy  <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_timer_zero) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.hold_PC        = w_stall;
  assign bus.hold_IF_ID     = w_stall;
  assign bus.hold_ID_EX     = 1'b0;
  assign bus.bubble_ID_EX   = w_stall;
  // A branch resolved in a stalled ID is re-evaluated once the stall clears.
  assign bus.flush_IF_ID    = bus.branch_taken_ID & ~w_stall;
  assign bus.muldiv_busy    = r_busy;
  assign bus.stall_cnt      = r_stall_cnt;

  assign bus.WriteReg_ID_EX = bus.WriteReg_ID & ~w_stall;
  assign bus.WriteMem_ID_EX = bus.WriteMem_ID & ~w_stall;
  assign bus.MemOrAlu_ID_EX = bus.MemOrAlu_ID & ~w_stall;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-count reference model of the HI/LO occupancy and stall counter.
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  localparam int MUL = 4;
  localparam int DIV = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(32)) if32 ();
  hazard_stall_ctrl_if #(.CNT_W(4))  if4 ();

  hazard_stall_ctrl #(.MUL_LAT(MUL), .DIV_LAT(DIV), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if32.slave)
  );

  hazard_stall_ctrl #(.MUL_LAT(MUL), .DIV_LAT(DIV), .CNT_W(4)) dut_c4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  assign if4.raddr_1_ID      = if32.raddr_1_ID;
  assign if4.raddr_2_ID      = if32.raddr_2_ID;
  assign if4.use_1_ID        = if32.use_1_ID;
  assign if4.use_2_ID        = if32.use_2_ID;
  assign if4.reads_hilo_ID   = if32.reads_hilo_ID;
  assign if4.muldiv_ID       = if32.muldiv_ID;
  assign if4.is_div_ID       = if32.is_div_ID;
  assign if4.MemOrAlu_EX     = if32.MemOrAlu_EX;
  assign if4.WriteReg_EX     = if32.WriteReg_EX;
  assign if4.wdest_EX        = if32.wdest_EX;
  assign if4.branch_taken_ID = if32.branch_taken_ID;
  assign if4.WriteReg_ID     = if32.WriteReg_ID;
  assign if4.WriteMem_ID     = if32.WriteMem_ID;
  assign if4.MemOrAlu_ID     = if32.MemOrAlu_ID;

  int errors = 0;
  int checks = 0;

  // Reference model: cycles of HI/LO occupancy left, and stall totals.
  int     rem  = 0;
  longint cnt  = 0;
  int     cnt4 = 0;

  function automatic bit m_ld_use();
    bit dep;
    dep = (if32.use_1_ID && (if32.raddr_1_ID == if32.wdest_EX)) ||
          (if32.use_2_ID && (if32.raddr_2_ID == if32.wdest_EX));
    return if32.MemOrAlu_EX && if32.WriteReg_EX && (if32.wdest_EX != 5'd0) && dep;
  endfunction

  function automatic bit m_stall();
    return m_ld_use() || ((rem > 0) && (if32.reads_hilo_ID || if32.muldiv_ID));
  endfunction

  task automatic model_reset();
    rem  = 0;
    cnt  = 0;
    cnt4 = 0;
  endtask

  task automatic advance();
    bit s;
    s = m_stall();
    if (s) begin
      if (cnt < 64'hFFFF_FFFF) cnt++;
      if (cnt4 < 15) cnt4++;
    end
    if (rem > 0) rem--;
    else if (if32.muldiv_ID && !s) rem = if32.is_div_ID ? DIV : MUL;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if32.raddr_1_ID      = '0;
    if32.raddr_2_ID      = '0;
    if32.use_1_ID        = 1'b0;
    if32.use_2_ID        = 1'b0;
    if32.reads_hilo_ID   = 1'b0;
    if32.muldiv_ID       = 1'b0;
    if32.is_div_ID       = 1'b0;
    if32.MemOrAlu_EX     = 1'b0;
    if32.WriteReg_EX     = 1'b0;
    if32.wdest_EX        = '0;
    if32.branch_taken_ID = 1'b0;
    if32.WriteReg_ID     = 1'b0;
    if32.WriteMem_ID     = 1'b0;
    if32.MemOrAlu_ID     = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (if32.muldiv_busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", if32.muldiv_busy);
    end
    checks++;
    if (if32.stall_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d expected 0", if32.stall_cnt);
    end
    checks++;
    if ({if32.hold_PC, if32.hold_IF_ID, if32.hold_ID_EX, if32.bubble_ID_EX, if32.flush_IF_ID} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000",
        {if32.hold_PC, if32.hold_IF_ID, if32.hold_ID_EX, if32.bubble_ID_EX, if32.flush_IF_ID});
    end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    clear_inputs();
    if32.MemOrAlu_EX = 1'b1; if32.WriteReg_EX = 1'b1; if32.wdest_EX = 5'd1;
    if32.raddr_1_ID = 5'd1; if32.use_1_ID = 1'b1;
    if32.raddr_2_ID = 5'd3; if32.use_2_ID = 1'b1;
    if32.WriteReg_ID = 1'b1;
    @(negedge clk);
    checks++;
    if ({if32.hold_PC, if32.hold_IF_ID, if32.bubble_ID_EX, if32.hold_ID_EX} !== 4'b1110) begin
      errors++; $display("FAIL lu_stall: got %b expected 1110",
        {if32.hold_PC, if32.hold_IF_ID, if32.bubble_ID_EX, if32.hold_ID_EX});
    end
    checks++;
    if (if32.WriteReg_ID_EX !== 1'b0) begin
      errors++; $display("FAIL lu_gate: got %b expected 0", if32.WriteReg_ID_EX);
    end
    advance();
    if32.MemOrAlu_EX = 1'b0; if32.WriteReg_EX = 1'b0; if32.wdest_EX = 5'd0;
    @(negedge clk);
    checks++;
    if (if32.hold_PC !== 1'b0) begin
      errors++; $display("FAIL lu_release: got %b expected 0", if32.hold_PC);
    end
    checks++;
    if (if32.stall_cnt !== 32'd1) begin
      errors++; $display("FAIL lu_cnt: got %0d expected 1", if32.stall_cnt);
    end
    checks++;
    if (if32.WriteReg_ID_EX !== 1'b1) begin
      errors++; $display("FAIL lu_pass: got %b expected 1", if32.WriteReg_ID_EX);
    end
    advance();
    $display("test_load_use done");
  endtask

  task automatic test_zero_dest();
    // {wdest, raddr1, use1, raddr2, use2, is_load, expected stall}
    logic [4:0] tw [4] = '{5'd0, 5'd5, 5'd6, 5'd6};
    logic [4:0] t1 [4] = '{5'd0, 5'd5, 5'd2, 5'd2};
    logic       u1 [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [4:0] t2 [4] = '{5'd9, 5'd7, 5'd6, 5'd6};
    logic       u2 [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       ld [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic       ex [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      clear_inputs();
      if32.MemOrAlu_EX = ld[i]; if32.WriteReg_EX = 1'b1; if32.wdest_EX = tw[i];
      if32.raddr_1_ID = t1[i]; if32.use_1_ID = u1[i];
      if32.raddr_2_ID = t2[i]; if32.use_2_ID = u2[i];
      @(negedge clk);
      checks++;
      if (if32.hold_PC !== ex[i]) begin
        errors++; $display("FAIL zero_dest_%0d: got %b expected %b", i, if32.hold_PC, ex[i]);
      end
      advance();
    end
    clear_inputs();
    $display("test_zero_dest done");
  endtask

  task automatic test_mult_mflo();
    clear_inputs();
    if32.muldiv_ID = 1'b1; if32.is_div_ID = 1'b0;
    @(negedge clk);
    checks++;
    if ({if32.hold_PC, if32.muldiv_busy} !== 2'b00) begin
      errors++; $display("FAIL mult_accept: got %b expected 00", {if32.hold_PC, if32.muldiv_busy});
    end
    advance();
    if32.muldiv_ID = 1'b0; if32.reads_hilo_ID = 1'b1;
    for (int k = 0; k <= MUL; k++) begin
      @(negedge clk);
      checks++;
      if ({if32.hold_PC, if32.muldiv_busy} !== {2{k < MUL}}) begin
        errors++; $display("FAIL mflo_c%0d: got %b expected %b", k,
          {if32.hold_PC, if32.muldiv_busy}, {2{k < MUL}});
      end
      advance();
    end
    clear_inputs();
    $display("test_mult_mflo done");
  endtask

  task automatic test_div_div();
    clear_inputs();
    if32.muldiv_ID = 1'b1; if32.is_div_ID = 1'b1;
    advance();
    for (int k = 0; k <= DIV; k++) begin
      @(negedge clk);
      checks++;
      if ({if32.hold_PC, if32.muldiv_busy} !== {2{k < DIV}}) begin
        errors++; $display("FAIL div2_c%0d: got %b expected %b", k,
          {if32.hold_PC, if32.muldiv_busy}, {2{k < DIV}});
      end
      advance();
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (if32.muldiv_busy !== 1'b1) begin
      errors++; $display("FAIL div2_rebusy: got %b expected 1", if32.muldiv_busy);
    end
    for (int g = 0; g < 12 && rem > 0; g++) advance();
    $display("test_div_div done");
  endtask

  task automatic test_branch_flush();
    clear_inputs();
    if32.MemOrAlu_EX = 1'b1; if32.WriteReg_EX = 1'b1; if32.wdest_EX = 5'd4;
    if32.raddr_2_ID = 5'd4; if32.use_2_ID = 1'b1; if32.branch_taken_ID = 1'b1;
    @(negedge clk);
    checks++;
    if ({if32.flush_IF_ID, if32.hold_PC} !== 2'b01) begin
      errors++; $display("FAIL br_stalled: got %b expected 01", {if32.flush_IF_ID, if32.hold_PC});
    end
    advance();
    if32.MemOrAlu_EX = 1'b0; if32.WriteReg_EX = 1'b0; if32.wdest_EX = 5'd0;
    @(negedge clk);
    checks++;
    if ({if32.flush_IF_ID, if32.hold_PC} !== 2'b10) begin
      errors++; $display("FAIL br_flush: got %b expected 10", {if32.flush_IF_ID, if32.hold_PC});
    end
    advance();
    clear_inputs();
    $display("test_branch_flush done");
  endtask

  task automatic test_reset_mid_busy();
    clear_inputs();
    if32.muldiv_ID = 1'b1; if32.is_div_ID = 1'b1;
    advance();
    if32.muldiv_ID = 1'b0; if32.reads_hilo_ID = 1'b1;
    repeat (4) advance();
    checks++;
    if (if32.muldiv_busy !== 1'b1 || if32.stall_cnt === 32'd0) begin
      errors++; $display("FAIL midbusy_pre: got busy=%b cnt=%0d expected busy=1 cnt>0",
        if32.muldiv_busy, if32.stall_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({if32.muldiv_busy, if32.hold_PC} !== 2'b00) begin
      errors++; $display("FAIL midbusy_rst: got %b expected 00", {if32.muldiv_busy, if32.hold_PC});
    end
    checks++;
    if (if32.stall_cnt !== 32'd0 || if4.stall_cnt !== 4'd0) begin
      errors++; $display("FAIL midbusy_cnt: got %0d/%0d expected 0/0", if32.stall_cnt, if4.stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    clear_inputs();
    @(posedge clk);
    #1;
    $display("test_reset_mid_busy done");
  endtask

  task automatic test_saturate();
    clear_inputs();
    if32.MemOrAlu_EX = 1'b1; if32.WriteReg_EX = 1'b1; if32.wdest_EX = 5'd8;
    if32.raddr_1_ID = 5'd8; if32.use_1_ID = 1'b1;
    repeat (20) advance();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (if4.stall_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_c4: got %0d expected 15", if4.stall_cnt);
    end
    checks++;
    if (if32.stall_cnt !== 32'd20) begin
      errors++; $display("FAIL sat_c32: got %0d expected 20", if32.stall_cnt);
    end
    advance();
    $display("test_saturate done");
  endtask

  task automatic test_random();
    bit s;
    for (int n = 0; n < 400; n++) begin
      if32.raddr_1_ID      = 5'($urandom_range(0, 3));
      if32.raddr_2_ID      = 5'($urandom_range(0, 3));
      if32.wdest_EX        = 5'($urandom_range(0, 3));
      if32.use_1_ID        = 1'($urandom_range(0, 1));
      if32.use_2_ID        = 1'($urandom_range(0, 1));
      if32.MemOrAlu_EX     = 1'($urandom_range(0, 1));
      if32.WriteReg_EX     = 1'($urandom_range(0, 1));
      if32.reads_hilo_ID   = ($urandom_range(0, 3) == 0);
      if32.muldiv_ID       = ($urandom_range(0, 3) == 0);
      if32.is_div_ID       = 1'($urandom_range(0, 1));
      if32.branch_taken_ID = 1'($urandom_range(0, 1));
      if32.WriteReg_ID     = 1'($urandom_range(0, 1));
      if32.WriteMem_ID     = 1'($urandom_range(0, 1));
      if32.MemOrAlu_ID     = 1'($urandom_range(0, 1));
      @(negedge clk);
      s = m_stall();
      checks++;
      if ({if32.hold_PC, if32.hold_IF_ID, if32.bubble_ID_EX, if32.hold_ID_EX} !== {s, s, s, 1'b0}) begin
        errors++; $display("FAIL rnd_hold n=%0d: got %b expected %b", n,
          {if32.hold_PC, if32.hold_IF_ID, if32.bubble_ID_EX, if32.hold_ID_EX}, {s, s, s, 1'b0});
      end
      checks++;
      if (if32.flush_IF_ID !== (if32.branch_taken_ID & ~s)) begin
        errors++; $display("FAIL rnd_flush n=%0d: got %b expected %b", n,
          if32.flush_IF_ID, if32.branch_taken_ID & ~s);
      end
      checks++;
      if (if32.muldiv_busy !== (rem > 0) || if4.muldiv_busy !== (rem > 0)) begin
        errors++; $display("FAIL rnd_busy n=%0d: got %b/%b expected %b", n,
          if32.muldiv_busy, if4.muldiv_busy, rem > 0);
      end
      checks++;
      if (if32.stall_cnt !== 32'(cnt) || if4.stall_cnt !== 4'(cnt4)) begin
        errors++; $display("FAIL rnd_cnt n=%0d: got %0d/%0d expected %0d/%0d", n,
          if32.stall_cnt, if4.stall_cnt, cnt, cnt4);
      end
      checks++;
      if ({if32.WriteReg_ID_EX, if32.WriteMem_ID_EX, if32.MemOrAlu_ID_EX} !==
          ({if32.WriteReg_ID, if32.WriteMem_ID, if32.MemOrAlu_ID} & {3{~s}})) begin
        errors++; $display("FAIL rnd_gate n=%0d: got %b expected %b", n,
          {if32.WriteReg_ID_EX, if32.WriteMem_ID_EX, if32.MemOrAlu_ID_EX},
          {if32.WriteReg_ID, if32.WriteMem_ID, if32.MemOrAlu_ID} & {3{~s}});
      end
      advance();
    end
    clear_inputs();
    $display("test_random done");
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_zero_dest();
    test_mult_mflo();
    test_div_div();
    test_branch_flush();
    test_reset_mid_busy();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
